// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared types for the I2C bus arbiter, its requesters and the PL I2C master.
//   ckrs_t        : bundled clock and synchronous active-high reset
//   i2c_cmd_t     : one register transaction (device, direction, register, write byte)
//   i2c_status_t  : completion status returned to the winning requester
//   arb_state_t   : arbiter sequencing states
package i2c_bus_arbiter_pkg;

    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;

    typedef struct packed {
        logic [6:0] dev;
        logic       rnw;
        logic [7:0] reg_addr;
        logic [7:0] wdata;
    } i2c_cmd_t;

    typedef enum logic [1:0] {
        I2C_OK      = 2'd0,
        I2C_NACK    = 2'd1,
        I2C_TIMEOUT = 2'd2
    } i2c_status_t;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_ISSUE  = 3'd1,
        ARB_WAIT   = 3'd2,
        ARB_ABORT  = 3'd3,
        ARB_REPORT = 3'd4
    } arb_state_t;

    localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

    // Saturating increment for the error counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == ERR_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req    : request vector
//   last   : index of the previous winner
//   onehot : one-hot winner (all zero when no request)
//   idx    : winner index
//   valid  : at least one request present
// The search starts one position above the previous winner and wraps, so the
// previous winner has the lowest priority.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    logic [IW-1:0] cand;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = (32'(base) + off) % NREQ;
        return IW'(s);
    endfunction

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = wrap_idx(last, i);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        onehot = valid ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one PL I2C master between NREQ requesters. Round-robin arbitration,
// one register transaction per grant, timeout watchdog with abort, status and
// read data returned to the winner.
//   ClkRs_ix     : clock + synchronous active-high reset
//   req_ib       : per-requester request level
//   cmd_ib       : per-requester transaction command
//   gnt_ob       : one-hot grant, held for the whole transaction
//   done_ob      : one-cycle completion pulse to the winner
//   status_ob    : completion status, held until the next completion
//   rdata_ob     : read byte (0 for writes/timeouts), held until the next completion
//   err_cnt_ob   : saturating count of NACK + TIMEOUT completions
//   mst_cmd_ob   : command to the master, latched at grant
//   mst_start_o  : one-cycle start pulse to the master
//   mst_abort_o  : one-cycle abort pulse to the master
//   mst_busy_i   : master active on the bus
//   mst_done_i   : master completion pulse
//   mst_nack_i   : NACK flag, qualified by mst_done_i
//   mst_rdata_ib : read byte, qualified by mst_done_i
//
// state  | meaning
// IDLE   | waiting for master idle and a request; arbitrates
// ISSUE  | start pulse to master is high
// WAIT   | watchdog running, waiting for master done
// ABORT  | watchdog expired; abort pulsed, waiting for master to go idle
// REPORT | done pulse to winner, grant released
module i2c_bus_arbiter
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  ckrs_t            ClkRs_ix,
    input  logic [NREQ-1:0]  req_ib,
    input  i2c_cmd_t         cmd_ib [NREQ],
    output logic [NREQ-1:0]  gnt_ob,
    output logic [NREQ-1:0]  done_ob,
    output i2c_status_t      status_ob,
    output logic [7:0]       rdata_ob,
    output logic [15:0]      err_cnt_ob,
    output i2c_cmd_t         mst_cmd_ob,
    output logic             mst_start_o,
    output logic             mst_abort_o,
    input  logic             mst_busy_i,
    input  logic             mst_done_i,
    input  logic             mst_nack_i,
    input  logic [7:0]       mst_rdata_ib
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t      state;
    logic [IW-1:0]   last;
    logic [TW-1:0]   timer;

    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req    (req_ib),
        .last   (last),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_ff @(posedge ClkRs_ix.clk) begin
        if (ClkRs_ix.reset) begin
            state       <= ARB_IDLE;
            last        <= IW'(NREQ - 1);
            timer       <= '0;
            gnt_ob      <= '0;
            done_ob     <= '0;
            status_ob   <= I2C_OK;
            rdata_ob    <= '0;
            err_cnt_ob  <= '0;
            mst_cmd_ob  <= '0;
            mst_start_o <= 1'b0;
            mst_abort_o <= 1'b0;
        end else begin
            mst_start_o <= 1'b0;
            mst_abort_o <= 1'b0;
            done_ob     <= '0;

            case (state)
                ARB_IDLE: begin
                    if (!mst_busy_i && pick_valid) begin
                        gnt_ob      <= pick_onehot;
                        mst_cmd_ob  <= cmd_ib[pick_idx];
                        last        <= pick_idx;
                        timer       <= '0;
                        mst_start_o <= 1'b1;
                        state       <= ARB_ISSUE;
                    end
                end

                // The start cycle itself counts toward the watchdog, so that
                // ABORT lands exactly TIMEOUT_CYCLES cycles after the start pulse.
                ARB_ISSUE: begin
                    timer <= timer + TW'(1);
                    state <= ARB_WAIT;
                end

                // Done is tested first so it wins over a coincident timeout.
                ARB_WAIT: begin
                    if (mst_done_i) begin
                        done_ob   <= gnt_ob;
                        rdata_ob  <= mst_cmd_ob.rnw ? mst_rdata_ib : 8'h00;
                        status_ob <= mst_nack_i ? I2C_NACK : I2C_OK;
                        if (mst_nack_i) begin
                            err_cnt_ob <= sat_inc16(err_cnt_ob);
                        end
                        state <= ARB_REPORT;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        mst_abort_o <= 1'b1;
                        state       <= ARB_ABORT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                // A late mst_done_i is deliberately ignored here.
                ARB_ABORT: begin
                    if (!mst_busy_i) begin
                        done_ob    <= gnt_ob;
                        rdata_ob   <= 8'h00;
                        status_ob  <= I2C_TIMEOUT;
                        err_cnt_ob <= sat_inc16(err_cnt_ob);
                        state      <= ARB_REPORT;
                    end
                end

                ARB_REPORT: begin
                    gnt_ob <= '0;
                    state  <= ARB_IDLE;
                end

                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
module tb_i2c_bus_arbiter;
    import i2c_bus_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int TO   = 100;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    ckrs_t           clk_rs;
    logic [NREQ-1:0] req_ib;
    i2c_cmd_t        cmd_ib [NREQ];
    logic [NREQ-1:0] gnt_ob;
    logic [NREQ-1:0] done_ob;
    i2c_status_t     status_ob;
    logic [7:0]      rdata_ob;
    logic [15:0]     err_cnt_ob;
    i2c_cmd_t        mst_cmd_ob;
    logic            mst_start;
    logic            mst_abort;
    logic            mst_busy;
    logic            mst_done;
    logic            mst_nack;
    logic [7:0]      mst_rdata;

    assign clk_rs = '{clk: clk, reset: rst};

    always #5 clk = ~clk;

    i2c_bus_arbiter #(
        .NREQ           (NREQ),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .ClkRs_ix     (clk_rs),
        .req_ib       (req_ib),
        .cmd_ib       (cmd_ib),
        .gnt_ob       (gnt_ob),
        .done_ob      (done_ob),
        .status_ob    (status_ob),
        .rdata_ob     (rdata_ob),
        .err_cnt_ob   (err_cnt_ob),
        .mst_cmd_ob   (mst_cmd_ob),
        .mst_start_o  (mst_start),
        .mst_abort_o  (mst_abort),
        .mst_busy_i   (mst_busy),
        .mst_done_i   (mst_done),
        .mst_nack_i   (mst_nack),
        .mst_rdata_ib (mst_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [NREQ-1:0] pend;
    int              last_m;
    int              err_m;
    i2c_status_t     st_m;
    logic [7:0]      rd_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // First pending requester above the previous winner, wrapping.
    function automatic int model_pick();
        for (int off = 1; off <= NREQ; off++) begin
            int c;
            c = (last_m + off) % NREQ;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    function automatic int gnt_index();
        for (int i = 0; i < NREQ; i++) if (gnt_ob[i]) return i;
        return -1;
    endfunction

    function automatic i2c_cmd_t rand_cmd();
        return i2c_cmd_t'(24'($urandom));
    endfunction

    task automatic check_all_zero(input string pfx);
        check({pfx, "_gnt"},   32'(gnt_ob), 0);
        check({pfx, "_done"},  32'(done_ob), 0);
        check({pfx, "_stat"},  32'(status_ob), 0);
        check({pfx, "_rdata"}, 32'(rdata_ob), 0);
        check({pfx, "_err"},   32'(err_cnt_ob), 0);
        check({pfx, "_cmd"},   32'(mst_cmd_ob), 0);
        check({pfx, "_start"}, 32'(mst_start), 0);
        check({pfx, "_abort"}, 32'(mst_abort), 0);
    endtask

    // Called at the falling edge of an IDLE cycle with pending requests driven
    // and the master idle. Returns at the falling edge of the following IDLE cycle.
    // mode: 0 = done after d cycles in WAIT, 1 = timeout (busy held b cycles in ABORT)
    task automatic do_txn(input int mode, input int d, input bit nack_v, input logic [7:0] rd_v,
                          input int b, input bit keep_req, input bit perturb, output int gidx);
        int          w;
        i2c_cmd_t    c_exp;
        bit          saw;
        i2c_status_t st_exp;
        logic [7:0]  rd_exp;

        w = model_pick();
        @(negedge clk);
        gidx = gnt_index();
        check("gnt", 32'(gnt_ob), 32'(1 << w));
        check("start", 32'(mst_start), 1);
        c_exp = cmd_ib[w];
        check("mst_cmd", 32'(mst_cmd_ob), 32'(c_exp));
        check("status_held", 32'(status_ob), 32'(st_m));
        check("rdata_held", 32'(rdata_ob), 32'(rd_m));
        last_m   = w;
        mst_busy = 1'b1;
        if (perturb) begin
            cmd_ib[w] = rand_cmd();
            req_ib[w] = 1'b0;
        end
        @(negedge clk);
        check("start_one_cycle", 32'(mst_start), 0);
        saw = mst_abort;

        if (mode == 0) begin
            repeat (d - 1) begin
                @(negedge clk);
                saw |= mst_abort;
            end
            mst_done  = 1'b1;
            mst_nack  = nack_v;
            mst_rdata = rd_v;
            @(negedge clk);
            saw |= mst_abort;
            check("no_abort", 32'(saw), 0);
            st_exp = nack_v ? I2C_NACK : I2C_OK;
            rd_exp = c_exp.rnw ? rd_v : 8'h00;
        end else begin
            repeat (TO - 2) begin
                @(negedge clk);
                saw |= mst_abort;
            end
            check("abort_early", 32'(saw), 0);
            @(negedge clk);
            check("abort_pulse", 32'(mst_abort), 1);
            saw = 1'b0;
            if (b > 0) begin
                mst_done  = 1'b1;
                mst_nack  = 1'b0;
                mst_rdata = 8'h3C;
            end
            repeat (b) begin
                @(negedge clk);
                mst_done = 1'b0;
                saw |= mst_abort | (done_ob != 0);
            end
            if (b > 0) check("abort_hold", 32'(saw), 0);
            mst_busy = 1'b0;
            @(negedge clk);
            st_exp = I2C_TIMEOUT;
            rd_exp = 8'h00;
        end

        mst_done  = 1'b0;
        mst_nack  = 1'b0;
        mst_busy  = 1'b0;
        mst_rdata = 8'($urandom);
        check("done", 32'(done_ob), 32'(1 << w));
        check("status", 32'(status_ob), 32'(st_exp));
        check("rdata", 32'(rdata_ob), 32'(rd_exp));
        if (st_exp != I2C_OK && err_m < 65535) err_m++;
        check("err_cnt", 32'(err_cnt_ob), 32'(err_m));
        check("gnt_in_report", 32'(gnt_ob), 32'(1 << w));
        check("cmd_stable", 32'(mst_cmd_ob), 32'(c_exp));
        st_m = st_exp;
        rd_m = rd_exp;
        pend[w] = keep_req;
        if (keep_req) cmd_ib[w] = rand_cmd();
        req_ib = pend;
        @(negedge clk);
        check("gnt_released", 32'(gnt_ob), 0);
        check("done_one_cycle", 32'(done_ob), 0);
    endtask

    initial begin
        int g;
        int order [6];
        bit saw;
        order = '{0, 1, 3, 0, 1, 3};

        req_ib    = '0;
        mst_busy  = 1'b0;
        mst_done  = 1'b0;
        mst_nack  = 1'b0;
        mst_rdata = 8'h00;
        for (int i = 0; i < NREQ; i++) cmd_ib[i] = '0;
        pend   = '0;
        last_m = NREQ - 1;
        err_m  = 0;
        st_m   = I2C_OK;
        rd_m   = 8'h00;

        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst = 1'b0;

        // round-robin with requests 0, 1, 3 held constantly
        pend = 4'b1011;
        for (int i = 0; i < NREQ; i++) cmd_ib[i] = rand_cmd();
        req_ib = pend;
        for (int i = 0; i < 6; i++) begin
            do_txn(0, $urandom_range(1, 20), 1'b0, 8'h00, 0, 1'b1, 1'b0, g);
            check("rr_order", 32'(g), 32'(order[i]));
        end
        pend   = '0;
        req_ib = pend;

        // single write from requester 2
        pend      = 4'b0100;
        cmd_ib[2] = '{dev: 7'h48, rnw: 1'b0, reg_addr: 8'h01, wdata: 8'h60};
        req_ib    = pend;
        do_txn(0, 50, 1'b0, 8'h77, 0, 1'b0, 1'b0, g);
        check("write_winner", 32'(g), 2);

        // read with NACK from requester 1
        pend      = 4'b0010;
        cmd_ib[1] = '{dev: 7'h20, rnw: 1'b1, reg_addr: 8'h10, wdata: 8'h00};
        req_ib    = pend;
        do_txn(0, 12, 1'b1, 8'hA5, 0, 1'b0, 1'b0, g);
        check("err_after_nack", 32'(err_cnt_ob), 1);

        // timeout, busy held 5 cycles into ABORT
        pend      = 4'b0001;
        cmd_ib[0] = '{dev: 7'h50, rnw: 1'b1, reg_addr: 8'h02, wdata: 8'h00};
        req_ib    = pend;
        do_txn(1, 0, 1'b0, 8'h00, 5, 1'b0, 1'b0, g);

        // done coincides with timeout: done wins
        pend      = 4'b1000;
        cmd_ib[3] = '{dev: 7'h11, rnw: 1'b1, reg_addr: 8'h33, wdata: 8'h00};
        req_ib    = pend;
        do_txn(0, TO - 1, 1'b0, 8'h5A, 0, 1'b0, 1'b0, g);

        // master busy with a request pending
        mst_busy  = 1'b1;
        pend      = 4'b0110;
        cmd_ib[1] = rand_cmd();
        cmd_ib[2] = rand_cmd();
        req_ib    = pend;
        saw = 1'b0;
        repeat (7) begin
            @(negedge clk);
            saw |= (gnt_ob != 0);
        end
        check("busy_no_gnt", 32'(saw), 0);
        mst_busy = 1'b0;
        do_txn(0, 8, 1'b0, 8'h00, 0, 1'b0, 1'b0, g);
        pend   = '0;
        req_ib = pend;

        // reset while in WAIT
        pend      = 4'b0110;
        cmd_ib[1] = rand_cmd();
        cmd_ib[2] = rand_cmd();
        req_ib    = pend;
        @(negedge clk);
        mst_busy = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rstw");
        rst      = 1'b0;
        mst_busy = 1'b0;
        last_m   = NREQ - 1;
        err_m    = 0;
        st_m     = I2C_OK;
        rd_m     = 8'h00;
        pend[0]  = 1'b1;
        cmd_ib[0] = rand_cmd();
        req_ib   = pend;
        do_txn(0, 5, 1'b0, 8'h00, 0, 1'b0, 1'b0, g);
        check("post_rst_winner", 32'(g), 0);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            int r;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]   = 1'b1;
                    cmd_ib[i] = rand_cmd();
                end
            end
            if (pend == 0) begin
                r = $urandom_range(0, NREQ - 1);
                pend[r]   = 1'b1;
                cmd_ib[r] = rand_cmd();
            end
            req_ib = pend;
            if ($urandom_range(0, 4) == 0) begin
                mst_busy = 1'b1;
                saw = 1'b0;
                repeat ($urandom_range(1, 6)) begin
                    @(negedge clk);
                    saw |= (gnt_ob != 0);
                end
                check("rand_busy_no_gnt", 32'(saw), 0);
                mst_busy = 1'b0;
            end
            r = $urandom_range(0, 9);
            if (r == 0)
                do_txn(1, 0, 1'b0, 8'h00, $urandom_range(0, 6),
                       $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, g);
            else if (r == 1)
                do_txn(0, TO - 1, $urandom_range(0, 1) == 1, 8'($urandom), 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, g);
            else
                do_txn(0, $urandom_range(1, 30), $urandom_range(0, 1) == 1, 8'($urandom), 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, g);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
